// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive packet controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and
// one combinational read port. Contents are not reset; the controller never
// reads a location it has not written in the current frame.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx: hunts for the sync byte, collects a
// length/payload/XOR-checksum frame, and releases verified payloads on a
// valid/ready byte stream while holding the receiver off.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for SYNC_BYTE, all other bytes ignored
//   LEN     | next byte is the payload length (1..MAX_LEN)
//   PAYLOAD | storing payload bytes into the buffer, folding the checksum
//   CSUM    | next byte must equal the running XOR of length and payload
//   DRAIN   | presenting buffered payload downstream, receiver gated off
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 104_170
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  // The idle cycle whose increment would land on TIMEOUT_CYCLES-1 ends the
  // frame, so the error pulse appears TIMEOUT_CYCLES cycles after the last byte.
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT_CYCLES - 2);

  state_t             state;
  err_t               err_q;
  logic [7:0]         len_q;
  logic [7:0]         csum;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [TMR_W-1:0]   tmr;

  logic               buf_we;
  logic [PTR_W-1:0]   rd_addr;
  logic [7:0]         rd_data;
  logic               tmr_hit;
  logic               len_ok;

  assign buf_we  = (state == PAYLOAD) && rx_valid;
  // In CSUM the first byte is fetched; in DRAIN the next byte is prefetched
  // so m_data can advance on the same edge that accepts the current byte.
  assign rd_addr = (state == DRAIN) ? rd_ptr + PTR_W'(1) : '0;
  assign tmr_hit = (tmr == TMR_FIRE);
  assign len_ok  = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));

  assign rx_en    = (state != DRAIN);
  assign busy     = (state != IDLE);
  assign err_code = err_q;

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Frame FSM with inter-byte timer, output stream registers and drop counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      err_q    <= ERR_NONE;
      len_q    <= '0;
      csum     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tmr      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;

      if ((state == LEN) || (state == PAYLOAD) || (state == CSUM)) begin
        if (rx_valid)     tmr <= '0;
        else if (!tmr_hit) tmr <= tmr + TMR_W'(1);
      end else begin
        tmr <= '0;
      end

      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) state <= LEN;
        end

        LEN: begin
          if (rx_valid) begin
            len_q <= rx_data;
            csum  <= rx_data;
            if (len_ok) begin
              wr_ptr <= '0;
              state  <= PAYLOAD;
            end else begin
              pkt_err <= 1'b1;
              err_q   <= ERR_LEN;
              state   <= IDLE;
            end
          end else if (tmr_hit) begin
            pkt_err <= 1'b1;
            err_q   <= ERR_TIMEOUT;
            state   <= IDLE;
          end
        end

        PAYLOAD: begin
          if (rx_valid) begin
            csum <= csum ^ rx_data;
            if (8'(wr_ptr) == len_q - 8'd1) state <= CSUM;
            else                            wr_ptr <= wr_ptr + PTR_W'(1);
          end else if (tmr_hit) begin
            pkt_err <= 1'b1;
            err_q   <= ERR_TIMEOUT;
            state   <= IDLE;
          end
        end

        CSUM: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              rd_ptr  <= '0;
              m_valid <= 1'b1;
              m_data  <= rd_data;
              m_last  <= (len_q == 8'd1);
              state   <= DRAIN;
            end else begin
              pkt_err <= 1'b1;
              err_q   <= ERR_CSUM;
              state   <= IDLE;
            end
          end else if (tmr_hit) begin
            pkt_err <= 1'b1;
            err_q   <= ERR_TIMEOUT;
            state   <= IDLE;
          end
        end

        DRAIN: begin
          if (rx_valid && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
          if (m_ready) begin
            if (m_last) begin
              m_valid  <= 1'b0;
              m_data   <= '0;
              m_last   <= 1'b0;
              pkt_done <= 1'b1;
              state    <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + PTR_W'(1);
              m_data <= rd_data;
              m_last <= (8'(rd_ptr) + 8'd2 == len_q);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
